// File: rtl/eth_rx_soft_gearbox_66b_pkg.sv
// Shared constants for the soft 64b/66b RX gearbox.
// Sync headers are written LSB-first: bit 0 is the first bit received on the line.
// cnt_width() sizes the fill counter so it can hold an un-emitted full buffer.
package eth_rx_soft_gearbox_66b_pkg;

  localparam logic [1:0] SYNC_DATA   = 2'b10;
  localparam logic [1:0] SYNC_CTRL   = 2'b01;
  localparam int         BLOCK_WIDTH = 66;

  // The intermediate total reaches 65 + in_width before a block is extracted.
  function automatic int cnt_width(input int in_width);
    return $clog2(BLOCK_WIDTH + in_width);
  endfunction

endpackage

// File: rtl/eth_rx_soft_gearbox_66b.sv
// Purpose : re-frames raw GT RX words into 66-bit blocks (2-bit sync header + 64 payload bits), with bitslip.
// Latency : 1 cycle from the input word that completes a block to rx_valid.
// Backpr. : none; the input is never stalled, and at most one block is emitted per cycle, so the buffer cannot overflow.
// Ports   : clk, rst (sync, active high); serdes_rx_data/valid/bitslip in (bit 0 earliest);
//           rx_data/rx_hdr/rx_valid/rx_bad_hdr out (registered); slip_ready out (high when a slip would be taken).
module eth_rx_soft_gearbox_66b
  import eth_rx_soft_gearbox_66b_pkg::*;
#(
  parameter int IN_WIDTH     = 64,
  parameter int HDR_WIDTH    = 2,
  parameter int SLIP_HOLDOFF = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [IN_WIDTH-1:0]               serdes_rx_data,
  input  logic                              serdes_rx_valid,
  input  logic                              serdes_rx_bitslip,
  output logic [BLOCK_WIDTH-HDR_WIDTH-1:0]  rx_data,
  output logic [HDR_WIDTH-1:0]              rx_hdr,
  output logic                              rx_valid,
  output logic                              rx_bad_hdr,
  output logic                              slip_ready
);

  localparam int PAY_W = BLOCK_WIDTH - HDR_WIDTH;
  localparam int BUF_W = BLOCK_WIDTH - 1 + IN_WIDTH;
  localparam int CW    = cnt_width(IN_WIDTH);
  localparam int HW    = (SLIP_HOLDOFF < 1) ? 1 : $clog2(SLIP_HOLDOFF + 1);

  // Bits at and above cnt_q in bits_q are always zero, so new words can be ORed in.
  logic [BUF_W-1:0]     bits_q, bits_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [HW-1:0]        holdoff_q, holdoff_d;
  logic [PAY_W-1:0]     rx_data_q, rx_data_d;
  logic [HDR_WIDTH-1:0] rx_hdr_q, rx_hdr_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_bad_hdr_q, rx_bad_hdr_d;

  logic [BUF_W-1:0]     merged;
  logic [CW-1:0]        total;
  logic                 slip_acc;

  assign slip_ready = (holdoff_q == '0);

  always_comb begin
    merged       = bits_q;
    total        = cnt_q;
    rx_data_d    = rx_data_q;
    rx_hdr_d     = rx_hdr_q;
    rx_valid_d   = 1'b0;
    rx_bad_hdr_d = 1'b0;

    // Append the new word directly above the bits already buffered.
    if (serdes_rx_valid) begin
      merged = bits_q | (BUF_W'(serdes_rx_data) << cnt_q);
      total  = cnt_q + CW'(IN_WIDTH);
    end

    // A slip drops the oldest bit before extraction, so a block emitted this
    // same cycle is already offset by one bit.
    slip_acc = serdes_rx_bitslip && slip_ready && (total != '0);
    if (slip_acc) begin
      merged = merged >> 1;
      total  = total - CW'(1);
    end

    if (total >= CW'(BLOCK_WIDTH)) begin
      rx_hdr_d     = merged[HDR_WIDTH-1:0];
      rx_data_d    = merged[BLOCK_WIDTH-1:HDR_WIDTH];
      rx_valid_d   = 1'b1;
      rx_bad_hdr_d = (rx_hdr_d != SYNC_DATA) && (rx_hdr_d != SYNC_CTRL);
      merged       = merged >> BLOCK_WIDTH;
      total        = total - CW'(BLOCK_WIDTH);
    end

    bits_d = merged;
    cnt_d  = total;

    // Requests arriving during the holdoff are dropped, not queued.
    holdoff_d = holdoff_q;
    if (slip_acc) begin
      holdoff_d = HW'(SLIP_HOLDOFF);
    end else if (holdoff_q != '0) begin
      holdoff_d = holdoff_q - HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q       <= '0;
      cnt_q        <= '0;
      holdoff_q    <= '0;
      rx_data_q    <= '0;
      rx_hdr_q     <= '0;
      rx_valid_q   <= 1'b0;
      rx_bad_hdr_q <= 1'b0;
    end else begin
      bits_q       <= bits_d;
      cnt_q        <= cnt_d;
      holdoff_q    <= holdoff_d;
      rx_data_q    <= rx_data_d;
      rx_hdr_q     <= rx_hdr_d;
      rx_valid_q   <= rx_valid_d;
      rx_bad_hdr_q <= rx_bad_hdr_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_hdr     = rx_hdr_q;
  assign rx_valid   = rx_valid_q;
  assign rx_bad_hdr = rx_bad_hdr_q;

endmodule
